branch_redirect_ctrl: RTL and testbench

//  Sequences control-flow redirects for the 16-bit core. Sits after the EX-stage branch comparator.

---
 rtl/cpu_branch_pkg.sv | 14 +
 rtl/sat_counter.sv | 23 ++
 rtl/branch_redirect_ctrl.sv | 122 ++++++++++++
 tb/tb_branch_redirect_ctrl.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/cpu_branch_pkg.sv
// Shared opcode, PC-select encodings and redirect FSM states for the branch redirect controller.
package cpu_branch_pkg;

  localparam logic [4:0] OPC_BE       = 5'b00011;
  localparam logic [1:0] PCSEL_SEQ    = 2'b00;
  localparam logic [1:0] PCSEL_BRANCH = 2'b01;

  typedef enum logic [1:0] {
    IDLE,
    REDIRECT,
    FLUSH
  } redir_state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: increments on inc, sticks at all-ones, cleared only by rst.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else if (inc && (count_q != '1)) begin
      count_q <= count_q + CNT_W'(1);
    end
  end

  assign count = count_q;

endmodule

// File: rtl/branch_redirect_ctrl.sv
// Redirect sequencer: one REDIRECT cycle then FLUSH cycles; freezes on stall.
// Optional statistics counters are enabled with the BRANCH_STATS_EN macro.
module branch_redirect_ctrl
  import cpu_branch_pkg::*;
#(
  parameter int ADDR_W       = 16,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_i,
  input  logic              ex_valid_i,
  input  logic [4:0]        ex_opcode_i,
  input  logic [1:0]        sel_pc_i,
  input  logic [ADDR_W-1:0] ex_target_i,
  output logic [1:0]        pc_src_o,
  output logic [ADDR_W-1:0] pc_target_o,
  output logic              flush_ifid_o,
  output logic              flush_idex_o,
  output logic              busy_o
`ifdef BRANCH_STATS_EN
  ,
  output logic [CNT_W-1:0]  br_exec_cnt_o,
  output logic [CNT_W-1:0]  br_taken_cnt_o
`endif
);

  localparam int FC_W = $clog2(FLUSH_CYCLES) + 1;

  redir_state_t      state_q, state_d;
  logic [FC_W-1:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0] target_q, target_d;
  logic [1:0]        pc_src_q, pc_src_d;
  logic              flush_q, flush_d;
  logic              take;

  assign take = (state_q == IDLE) & ex_valid_i & ~stall_i & (sel_pc_i == PCSEL_BRANCH);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    target_d = target_q;
    case (state_q)
      IDLE: begin
        if (take) begin
          state_d  = REDIRECT;
          target_d = ex_target_i;
        end
      end
      REDIRECT: begin
        if (!stall_i) begin
          if (FLUSH_CYCLES == 1) begin
            state_d = IDLE;
          end else begin
            state_d = FLUSH;
            cnt_d   = FC_W'(FLUSH_CYCLES - 2);
          end
        end
      end
      FLUSH: begin
        if (!stall_i) begin
          if (cnt_q == '0) state_d = IDLE;
          else             cnt_d   = cnt_q - FC_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are decoded from the next state so they land in registers.
    pc_src_d = (state_d == REDIRECT) ? PCSEL_BRANCH : PCSEL_SEQ;
    flush_d  = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      target_q <= '0;
      pc_src_q <= PCSEL_SEQ;
      flush_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      target_q <= target_d;
      pc_src_q <= pc_src_d;
      flush_q  <= flush_d;
    end
  end

  assign pc_src_o     = pc_src_q;
  assign pc_target_o  = target_q;
  assign flush_ifid_o = flush_q;
  assign flush_idex_o = flush_q;
  assign busy_o       = flush_q;

`ifdef BRANCH_STATS_EN
  logic exec_inc;
  assign exec_inc = (state_q == IDLE) & ex_valid_i & ~stall_i & (ex_opcode_i == OPC_BE);

  sat_counter #(.CNT_W(CNT_W)) u_exec_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (exec_inc),
    .count (br_exec_cnt_o)
  );

  sat_counter #(.CNT_W(CNT_W)) u_taken_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (take),
    .count (br_taken_cnt_o)
  );
`else
  // Opcode and counter width only matter to the statistics block.
  logic             unused_opcode;
  logic [CNT_W-1:0] unused_cnt_w;
  assign unused_opcode = ^ex_opcode_i;
  assign unused_cnt_w  = '0;
`endif

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Self-checking bench for branch_redirect_ctrl: vector table, directed corner sequences,
// and randomized traffic against a bubble-countdown reference model.
module tb_branch_redirect_ctrl;

  localparam int FC = 2;
`ifdef BRANCH_STATS_EN
  localparam int CW = 4;
`else
  localparam int CW = 16;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        valid;
  logic [4:0]  opcode;
  logic [1:0]  sel;
  logic [15:0] target;
  logic [1:0]  pc_src;
  logic [15:0] pc_target;
  logic        fl_ifid, fl_idex, busy;
`ifdef BRANCH_STATS_EN
  logic [CW-1:0] exec_cnt, taken_cnt;
`endif

  always #5 clk = ~clk;

  branch_redirect_ctrl #(.ADDR_W(16), .FLUSH_CYCLES(FC), .CNT_W(CW)) dut (
    .clk          (clk),
    .rst          (rst),
    .stall_i      (stall),
    .ex_valid_i   (valid),
    .ex_opcode_i  (opcode),
    .sel_pc_i     (sel),
    .ex_target_i  (target),
    .pc_src_o     (pc_src),
    .pc_target_o  (pc_target),
    .flush_ifid_o (fl_ifid),
    .flush_idex_o (fl_idex),
    .busy_o       (busy)
`ifdef BRANCH_STATS_EN
    ,
    .br_exec_cnt_o  (exec_cnt),
    .br_taken_cnt_o (taken_cnt)
`endif
  );

  int checks   = 0;
  int failures = 0;
  int txn      = 0;

  // Reference model: number of bubble cycles still owed, and the latched target.
  int          m_rem = 0;
  logic [15:0] m_tgt = '0;

  typedef struct {
    logic        stall;
    logic        valid;
    logic [1:0]  sel;
    logic [15:0] tgt;
    logic [1:0]  e_src;
    logic [15:0] e_tgt;
    logic        e_fl;
    logic        e_busy;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (txn %0d)", nm, act, exp, txn);
    end
  endtask

  task automatic drive_edge(input logic r, input logic st, input logic v,
                            input logic [1:0] s, input logic [15:0] tg);
    rst = r; stall = st; valid = v; sel = s; target = tg;
    @(posedge clk);
    if (r) begin
      m_rem = 0;
      m_tgt = '0;
    end else if (m_rem > 0) begin
      if (!st) m_rem--;
    end else if (v && !st && s == 2'b01) begin
      m_rem = FC;
      m_tgt = tg;
    end
    #1;
    txn++;
    $display("txn %0d rst=%0b stall=%0b valid=%0b sel=%0d tgt=%h -> src=%0d pc_tgt=%h flush=%0b%0b busy=%0b",
             txn, r, st, v, s, tg, pc_src, pc_target, fl_ifid, fl_idex, busy);
  endtask

  task automatic chk_model();
    chk("model_pc_src", 32'(pc_src), (m_rem == FC) ? 32'd1 : 32'd0);
    chk("model_pc_target", 32'(pc_target), 32'(m_tgt));
    chk("model_flush_ifid", 32'(fl_ifid), (m_rem > 0) ? 32'd1 : 32'd0);
    chk("model_flush_idex", 32'(fl_idex), (m_rem > 0) ? 32'd1 : 32'd0);
    chk("model_busy", 32'(busy), (m_rem > 0) ? 32'd1 : 32'd0);
  endtask

  task automatic chk_outs(input string nm, input logic [1:0] e_src, input logic [15:0] e_tgt,
                          input logic e_fl, input logic e_busy);
    chk({nm, "_pc_src"}, 32'(pc_src), 32'(e_src));
    chk({nm, "_pc_target"}, 32'(pc_target), 32'(e_tgt));
    chk({nm, "_flush_ifid"}, 32'(fl_ifid), 32'(e_fl));
    chk({nm, "_flush_idex"}, 32'(fl_idex), 32'(e_fl));
    chk({nm, "_busy"}, 32'(busy), 32'(e_busy));
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; valid = 1'b0; opcode = 5'b00011; sel = 2'b00; target = '0;

    // Vector table: not-taken, reserved, taken, squash, idle-stall, back-to-back.
    vecs[0]  = '{1'b0, 1'b1, 2'b00, 16'h1111, 2'b00, 16'h0000, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, 2'b11, 16'h2222, 2'b00, 16'h0000, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 2'b01, 16'h0040, 2'b01, 16'h0040, 1'b1, 1'b1};
    vecs[3]  = '{1'b0, 1'b1, 2'b01, 16'h0099, 2'b00, 16'h0040, 1'b1, 1'b1};
    vecs[4]  = '{1'b0, 1'b0, 2'b00, 16'h0000, 2'b00, 16'h0040, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 1'b1, 2'b01, 16'h1234, 2'b00, 16'h0040, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 2'b01, 16'h1234, 2'b01, 16'h1234, 1'b1, 1'b1};
    vecs[7]  = '{1'b0, 1'b1, 2'b01, 16'h5555, 2'b00, 16'h1234, 1'b1, 1'b1};
    vecs[8]  = '{1'b0, 1'b1, 2'b01, 16'h0777, 2'b00, 16'h1234, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 2'b01, 16'h0777, 2'b01, 16'h0777, 1'b1, 1'b1};
    vecs[10] = '{1'b0, 1'b0, 2'b00, 16'h0000, 2'b00, 16'h0777, 1'b1, 1'b1};
    vecs[11] = '{1'b0, 1'b0, 2'b00, 16'h0000, 2'b00, 16'h0777, 1'b0, 1'b0};
    vecs[12] = '{1'b0, 1'b1, 2'b10, 16'hABCD, 2'b00, 16'h0777, 1'b0, 1'b0};

    drive_edge(1'b1, 1'b0, 1'b0, 2'b00, 16'h0000);
    drive_edge(1'b1, 1'b0, 1'b0, 2'b00, 16'h0000);
    chk_outs("reset", 2'b00, 16'h0000, 1'b0, 1'b0);

    for (int i = 0; i < 13; i++) begin
      drive_edge(1'b0, vecs[i].stall, vecs[i].valid, vecs[i].sel, vecs[i].tgt);
      chk_outs($sformatf("vec%0d", i), vecs[i].e_src, vecs[i].e_tgt, vecs[i].e_fl, vecs[i].e_busy);
    end

    // Stall held for 3 cycles in REDIRECT, with a squashed branch presented throughout.
    drive_edge(1'b1, 1'b0, 1'b0, 2'b00, 16'h0000);
    drive_edge(1'b0, 1'b0, 1'b1, 2'b01, 16'h0040);
    chk_outs("stall_redir0", 2'b01, 16'h0040, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      drive_edge(1'b0, 1'b1, 1'b1, 2'b01, 16'h0099);
      chk_outs($sformatf("stall_hold%0d", i), 2'b01, 16'h0040, 1'b1, 1'b1);
    end
    drive_edge(1'b0, 1'b0, 1'b1, 2'b01, 16'h0099);
    chk_outs("stall_flush", 2'b00, 16'h0040, 1'b1, 1'b1);
    drive_edge(1'b0, 1'b0, 1'b0, 2'b00, 16'h0000);
    chk_outs("stall_idle", 2'b00, 16'h0040, 1'b0, 1'b0);

    // Reset asserted for 3 cycles while in FLUSH.
    drive_edge(1'b0, 1'b0, 1'b1, 2'b01, 16'h0BEE);
    drive_edge(1'b0, 1'b0, 1'b0, 2'b00, 16'h0000);
    chk_outs("pre_reset_flush", 2'b00, 16'h0BEE, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) drive_edge(1'b1, 1'b0, 1'b1, 2'b01, 16'h0BAD);
    chk_outs("mid_reset", 2'b00, 16'h0000, 1'b0, 1'b0);
    drive_edge(1'b0, 1'b0, 1'b0, 2'b00, 16'h0000);
    chk_outs("post_reset", 2'b00, 16'h0000, 1'b0, 1'b0);

    // Randomized traffic against the reference model.
    for (int i = 0; i < 400; i++) begin
      opcode = 5'($urandom);
      drive_edge(($urandom_range(0, 49) == 0),
                 ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 9) < 7),
                 2'($urandom),
                 16'($urandom));
      chk_model();
    end

`ifdef BRANCH_STATS_EN
    opcode = 5'b00011;
    drive_edge(1'b1, 1'b0, 1'b0, 2'b00, 16'h0000);
    chk("stats_reset_exec", 32'(exec_cnt), 32'd0);
    chk("stats_reset_taken", 32'(taken_cnt), 32'd0);
    for (int i = 0; i < 20; i++) begin
      drive_edge(1'b0, 1'b0, 1'b1, 2'b01, 16'(i));
      drive_edge(1'b0, 1'b0, 1'b1, 2'b01, 16'h0000);
      drive_edge(1'b0, 1'b0, 1'b0, 2'b00, 16'h0000);
      if (i == 4) begin
        chk("stats_exec5", 32'(exec_cnt), 32'd5);
        chk("stats_taken5", 32'(taken_cnt), 32'd5);
      end
    end
    chk("stats_exec_sat", 32'(exec_cnt), 32'hF);
    chk("stats_taken_sat", 32'(taken_cnt), 32'hF);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
